counter_cmd_gen: RTL and testbench

//  Upstream command stage for the up/down counter. Takes raw push-buttons
//  (up, down, load) and a switch bank, then synchronises and debounces them.

---
 rtl/counter_pkg.sv | 22 ++
 rtl/counter_cmd_gen_btn_debounce.sv | 54 +++++
 rtl/counter_cmd_gen.sv | 131 +++++++++++++
 tb/tb_counter_cmd_gen.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// counter_pkg : shared types for the counter command generator
// Rev 1.0
// ----------------------------------------------------------------------------
package counter_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        HOLD = 2'd2
    } cmd_state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage
`default_nettype wire

// File: rtl/counter_cmd_gen_btn_debounce.sv
`default_nettype none
// ----------------------------------------------------------------------------
// btn_debounce : 2-FF synchroniser plus stability counter for one raw button
// Rev 1.0
// ----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn_i,
    output logic stable_o,
    output logic rise_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             rise_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            if (sync2_q != stable_q) begin
                if (cnt_q == CNT_MAX) begin
                    stable_q <= sync2_q;
                    rise_q   <= sync2_q;
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;

endmodule
`default_nettype wire

// File: rtl/counter_cmd_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// counter_cmd_gen : debounced buttons -> step/direction/load commands
// Rev 1.0
// ----------------------------------------------------------------------------
module counter_cmd_gen
    import counter_pkg::*;
#(
    parameter int WIDTH           = WIDTH_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             btn_up_i,
    input  logic             btn_down_i,
    input  logic             btn_load_i,
    input  logic [WIDTH-1:0] sw_value_i,
    output logic             up_o,
    output logic             down_o,
    output logic             enable_o,
    output logic [WIDTH-1:0] init_value_o,
    output logic             init_valid_o
);

    localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

    logic up_db, down_db, load_db;
    logic up_rise, down_rise, load_rise;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk_i(clk_i), .reset_i(reset_i), .btn_i(btn_up_i),
        .stable_o(up_db), .rise_o(up_rise)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk_i(clk_i), .reset_i(reset_i), .btn_i(btn_down_i),
        .stable_o(down_db), .rise_o(down_rise)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clk_i(clk_i), .reset_i(reset_i), .btn_i(btn_load_i),
        .stable_o(load_db), .rise_o(load_rise)
    );

    // Step buttons are level-driven and load is edge-driven, so these go unread.
    logic unused_db;
    assign unused_db = ^{up_rise, down_rise, load_db};

    cmd_state_e       state_q;
    dir_e             dir_q;
    logic [RPT_W-1:0] rpt_q;
    logic             up_q, down_q, enable_q;
    logic [WIDTH-1:0] init_value_q;
    logic             init_valid_q;

    logic w_dir_held;
    assign w_dir_held = (dir_q == DIR_UP) ? up_db : down_db;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q  <= IDLE;
            dir_q    <= DIR_UP;
            rpt_q    <= '0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            enable_q <= 1'b0;
        end else begin
            enable_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (up_db ^ down_db) begin
                        dir_q    <= up_db ? DIR_UP : DIR_DOWN;
                        up_q     <= up_db;
                        down_q   <= down_db;
                        enable_q <= 1'b1;
                        state_q  <= STEP;
                    end else if (up_db && down_db) begin
                        rpt_q   <= '0;
                        state_q <= HOLD;
                    end
                end
                STEP: begin
                    rpt_q   <= '0;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (!up_db && !down_db) begin
                        state_q <= IDLE;
                    end else if (up_db && down_db) begin
                        rpt_q <= '0;
                    end else if (w_dir_held) begin
                        if (REPEAT_CYCLES != 0) begin
                            if (rpt_q == RPT_MAX) begin
                                up_q     <= (dir_q == DIR_UP);
                                down_q   <= (dir_q == DIR_DOWN);
                                enable_q <= 1'b1;
                                state_q  <= STEP;
                            end else begin
                                rpt_q <= rpt_q + RPT_W'(1);
                            end
                        end
                    end else begin
                        // Opposite button alone: let IDLE pick it up as a new press.
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            init_value_q <= '0;
            init_valid_q <= 1'b0;
        end else begin
            init_valid_q <= load_rise;
            if (load_rise) begin
                init_value_q <= sw_value_i;
            end
        end
    end

    assign up_o         = up_q;
    assign down_o       = down_q;
    assign enable_o     = enable_q;
    assign init_value_o = init_value_q;
    assign init_valid_o = init_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_cmd_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_counter_cmd_gen : scoreboard bench, one DUT with auto-repeat, one without
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_counter_cmd_gen;
    import counter_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n, btn_up, btn_down, btn_load;
    logic [W-1:0] sw;

    logic         up_r, down_r, en_r, iv_r;
    logic [W-1:0] ival_r;
    logic         up_n, down_n, en_n, iv_n;
    logic [W-1:0] ival_n;

    counter_cmd_gen #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8)) dut_r (
        .clk_i(clk), .reset_i(reset_n), .btn_up_i(btn_up), .btn_down_i(btn_down),
        .btn_load_i(btn_load), .sw_value_i(sw), .up_o(up_r), .down_o(down_r),
        .enable_o(en_r), .init_value_o(ival_r), .init_valid_o(iv_r)
    );

    counter_cmd_gen #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(0)) dut_n (
        .clk_i(clk), .reset_i(reset_n), .btn_up_i(btn_up), .btn_down_i(btn_down),
        .btn_load_i(btn_load), .sw_value_i(sw), .up_o(up_n), .down_o(down_n),
        .enable_o(en_n), .init_value_o(ival_n), .init_valid_o(iv_n)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {int cyc; logic up; logic down;} step_t;
    typedef struct {int cyc; logic [W-1:0] val;} load_t;
    step_t q_r[$], q_n[$];
    load_t ql_r[$], ql_n[$];
    step_t er, en;
    load_t lr, ln;
    logic en_prev_r = 1'b0, en_prev_n = 1'b0;
    logic iv_prev_r = 1'b0, iv_prev_n = 1'b0;

    // Scoreboard for the repeating DUT
    always @(negedge clk) begin
        n_checks++;
        if (up_r && down_r) begin
            n_fail++;
            $display("FAIL r_dir_onehot: cyc=%0d up=%b down=%b, required not both 1", cyc, up_r, down_r);
        end
        if (en_r) begin
            n_checks++;
            if (q_r.size() == 0) begin
                n_fail++;
                $display("FAIL r_step_unexpected: cyc=%0d up=%b down=%b, required no step", cyc, up_r, down_r);
            end else begin
                er = q_r.pop_front();
                if (cyc !== er.cyc || up_r !== er.up || down_r !== er.down) begin
                    n_fail++;
                    $display("FAIL r_step: cyc=%0d up=%b down=%b, required cyc=%0d up=%b down=%b",
                             cyc, up_r, down_r, er.cyc, er.up, er.down);
                end
            end
            n_checks++;
            if (en_prev_r) begin
                n_fail++;
                $display("FAIL r_enable_width: cyc=%0d enable high 2 cycles, required 1", cyc);
            end
        end
        if (iv_r) begin
            n_checks++;
            if (ql_r.size() == 0) begin
                n_fail++;
                $display("FAIL r_load_unexpected: cyc=%0d value=%0d, required no load", cyc, ival_r);
            end else begin
                lr = ql_r.pop_front();
                if (cyc !== lr.cyc || ival_r !== lr.val || iv_prev_r) begin
                    n_fail++;
                    $display("FAIL r_load: cyc=%0d value=%0d prev_valid=%b, required cyc=%0d value=%0d prev_valid=0",
                             cyc, ival_r, iv_prev_r, lr.cyc, lr.val);
                end
            end
        end
        en_prev_r = en_r;
        iv_prev_r = iv_r;
    end

    // Scoreboard for the non-repeating DUT
    always @(negedge clk) begin
        if (en_n) begin
            n_checks++;
            if (q_n.size() == 0) begin
                n_fail++;
                $display("FAIL n_step_unexpected: cyc=%0d up=%b down=%b, required no step", cyc, up_n, down_n);
            end else begin
                en = q_n.pop_front();
                if (cyc !== en.cyc || up_n !== en.up || down_n !== en.down || en_prev_n) begin
                    n_fail++;
                    $display("FAIL n_step: cyc=%0d up=%b down=%b prev_en=%b, required cyc=%0d up=%b down=%b prev_en=0",
                             cyc, up_n, down_n, en_prev_n, en.cyc, en.up, en.down);
                end
            end
        end
        if (iv_n) begin
            n_checks++;
            if (ql_n.size() == 0) begin
                n_fail++;
                $display("FAIL n_load_unexpected: cyc=%0d value=%0d, required no load", cyc, ival_n);
            end else begin
                ln = ql_n.pop_front();
                if (cyc !== ln.cyc || ival_n !== ln.val || iv_prev_n) begin
                    n_fail++;
                    $display("FAIL n_load: cyc=%0d value=%0d prev_valid=%b, required cyc=%0d value=%0d prev_valid=0",
                             cyc, ival_n, iv_prev_n, ln.cyc, ln.val);
                end
            end
        end
        en_prev_n = en_n;
        iv_prev_n = iv_n;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0; btn_up = 1'b1; btn_down = 1'b1; btn_load = 1'b1; sw = 8'hA5;
        wait_cyc(2);
        n_checks++;
        if ({up_r, down_r, en_r, iv_r} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_r_flags: got %b, required 0000", {up_r, down_r, en_r, iv_r});
        end
        n_checks++;
        if (ival_r !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_r_init_value: got %0d, required 0", ival_r);
        end
        n_checks++;
        if (dut_r.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL reset_r_state: got %0d, required %0d", dut_r.state_q, IDLE);
        end
        n_checks++;
        if ({up_n, down_n, en_n, iv_n} !== 4'b0000 || ival_n !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_n_outputs: got flags %b value %0d, required 0000 and 0",
                     {up_n, down_n, en_n, iv_n}, ival_n);
        end
        btn_up = 1'b0; btn_down = 1'b0; btn_load = 1'b0;
        wait_cyc(2);
        reset_n = 1'b1;
        wait_cyc(12);
        n_checks++;
        if (q_r.size() != 0 || q_n.size() != 0 || ql_r.size() != 0 || ql_n.size() != 0) begin
            n_fail++;
            $display("FAIL reset_drain: pending %0d/%0d/%0d/%0d, required 0",
                     q_r.size(), q_n.size(), ql_r.size(), ql_n.size());
            q_r.delete(); q_n.delete(); ql_r.delete(); ql_n.delete();
        end
    endtask

    task automatic test_single_step;
        int p;
        p = cyc;
        btn_up = 1'b1;
        q_n.push_back(step_t'{p + 7, 1'b1, 1'b0});
        for (int k = 0; k < 5; k++) q_r.push_back(step_t'{p + 7 + 9 * k, 1'b1, 1'b0});
        wait_cyc(40);
        btn_up = 1'b0;
        wait_cyc(14);
        n_checks++;
        if (up_n !== 1'b1 || down_n !== 1'b0) begin
            n_fail++;
            $display("FAIL single_dir_hold: up=%b down=%b, required up=1 down=0", up_n, down_n);
        end
        n_checks++;
        if (q_r.size() != 0 || q_n.size() != 0) begin
            n_fail++;
            $display("FAIL single_drain: pending %0d/%0d, required 0", q_r.size(), q_n.size());
            q_r.delete(); q_n.delete();
        end
    endtask

    task automatic test_repeat;
        int p;
        p = cyc;
        btn_down = 1'b1;
        q_n.push_back(step_t'{p + 7, 1'b0, 1'b1});
        for (int k = 0; k < 4; k++) q_r.push_back(step_t'{p + 7 + 9 * k, 1'b0, 1'b1});
        wait_cyc(36);
        btn_down = 1'b0;
        wait_cyc(14);
        n_checks++;
        if (up_r !== 1'b0 || down_r !== 1'b1) begin
            n_fail++;
            $display("FAIL repeat_dir: up=%b down=%b, required up=0 down=1", up_r, down_r);
        end
        n_checks++;
        if (q_r.size() != 0 || q_n.size() != 0) begin
            n_fail++;
            $display("FAIL repeat_drain: pending %0d/%0d, required 0", q_r.size(), q_n.size());
            q_r.delete(); q_n.delete();
        end
    endtask

    task automatic test_bounce_and_both;
        int t;
        t = cyc;
        for (int i = 0; i < 6; i++) begin
            btn_down = (i % 2 == 0);
            wait_cyc(2);
        end
        btn_down = 1'b1;
        q_r.push_back(step_t'{t + 19, 1'b0, 1'b1});
        q_n.push_back(step_t'{t + 19, 1'b0, 1'b1});
        wait_cyc(8);
        btn_down = 1'b0;
        wait_cyc(12);
        n_checks++;
        if (q_r.size() != 0 || q_n.size() != 0) begin
            n_fail++;
            $display("FAIL bounce_drain: pending %0d/%0d, required 0", q_r.size(), q_n.size());
            q_r.delete(); q_n.delete();
        end
        btn_up = 1'b1; btn_down = 1'b1;
        wait_cyc(20);
        n_checks++;
        if (dut_r.state_q !== HOLD) begin
            n_fail++;
            $display("FAIL both_state: got %0d, required %0d", dut_r.state_q, HOLD);
        end
        btn_up = 1'b0; btn_down = 1'b0;
        wait_cyc(12);
        n_checks++;
        if (up_r !== 1'b0 || down_r !== 1'b1 || dut_r.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL both_after: up=%b down=%b state=%0d, required up=0 down=1 state=%0d",
                     up_r, down_r, dut_r.state_q, IDLE);
        end
    endtask

    task automatic test_load;
        int p;
        sw = 8'd180;
        p = cyc;
        btn_load = 1'b1;
        ql_r.push_back(load_t'{p + 7, 8'd180});
        ql_n.push_back(load_t'{p + 7, 8'd180});
        wait_cyc(8);
        sw = 8'd6;
        wait_cyc(2);
        btn_load = 1'b0;
        wait_cyc(12);
        n_checks++;
        if (ival_r !== 8'd180 || ival_n !== 8'd180 || iv_r !== 1'b0) begin
            n_fail++;
            $display("FAIL load_hold: value=%0d/%0d valid=%b, required 180/180 valid=0", ival_r, ival_n, iv_r);
        end
        p = cyc;
        btn_load = 1'b1;
        ql_r.push_back(load_t'{p + 7, 8'd6});
        ql_n.push_back(load_t'{p + 7, 8'd6});
        wait_cyc(10);
        btn_load = 1'b0;
        wait_cyc(12);
        n_checks++;
        if (ival_r !== 8'd6) begin
            n_fail++;
            $display("FAIL load_second: value=%0d, required 6", ival_r);
        end
        n_checks++;
        if (ql_r.size() != 0 || ql_n.size() != 0) begin
            n_fail++;
            $display("FAIL load_drain: pending %0d/%0d, required 0", ql_r.size(), ql_n.size());
            ql_r.delete(); ql_n.delete();
        end
    endtask

    task automatic test_reset_mid_hold;
        int p, r0;
        p = cyc;
        btn_up = 1'b1;
        q_r.push_back(step_t'{p + 7, 1'b1, 1'b0});
        q_r.push_back(step_t'{p + 16, 1'b1, 1'b0});
        q_n.push_back(step_t'{p + 7, 1'b1, 1'b0});
        wait_cyc(20);
        reset_n = 1'b0;
        wait_cyc(1);
        n_checks++;
        if ({up_r, down_r, en_r, iv_r} !== 4'b0000 || ival_r !== 8'd0 || dut_r.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL midreset_r: flags=%b value=%0d state=%0d, required 0000 0 %0d",
                     {up_r, down_r, en_r, iv_r}, ival_r, dut_r.state_q, IDLE);
        end
        n_checks++;
        if ({up_n, down_n, en_n, iv_n} !== 4'b0000 || ival_n !== 8'd0) begin
            n_fail++;
            $display("FAIL midreset_n: flags=%b value=%0d, required 0000 0", {up_n, down_n, en_n, iv_n}, ival_n);
        end
        reset_n = 1'b1;
        r0 = cyc;
        q_r.push_back(step_t'{r0 + 7, 1'b1, 1'b0});
        q_n.push_back(step_t'{r0 + 7, 1'b1, 1'b0});
        wait_cyc(9);
        btn_up = 1'b0;
        wait_cyc(14);
        n_checks++;
        if (q_r.size() != 0 || q_n.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_drain: pending %0d/%0d, required 0", q_r.size(), q_n.size());
            q_r.delete(); q_n.delete();
        end
    endtask

    initial begin
        reset_n = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_load = 1'b0; sw = '0;
        @(negedge clk);
        test_reset();
        test_single_step();
        test_repeat();
        test_bounce_and_both();
        test_load();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
